// File: rtl/qsys_ram_arbiter.sv
// qsys_ram_arbiter: two-master round-robin arbiter in front of a single-port 1024x32 RAM
module qsys_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);
  localparam bit fp = FIXED_PRIORITY != 0;
  logic req0, req1, gnt0, gnt1, last_q, rv_q, rown_q;
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = ~reset & req0 & (~req1 | fp | last_q);
    gnt1 = ~reset & req1 & ~gnt0;
    m0_waitrequest = req0 & ~gnt0;
    m1_waitrequest = req1 & ~gnt1;
    ram_address = gnt1 ? m1_address : m0_address;
    ram_writedata = gnt1 ? m1_writedata : m0_writedata;
    ram_byteenable = gnt1 ? m1_byteenable : gnt0 ? m0_byteenable : '0;
    ram_chipselect = gnt0 | gnt1;
    ram_write = gnt1 ? m1_write : gnt0 & m0_write;
    ram_clken = 1'b1;
    m0_readdata = ram_readdata;
    m1_readdata = ram_readdata;
    // masking with reset drops a read whose data would land in a reset cycle
    m0_readdatavalid = ~reset & rv_q & ~rown_q;
    m1_readdatavalid = ~reset & rv_q & rown_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      rv_q <= 1'b0;
      rown_q <= 1'b0;
    end else begin
      last_q <= ram_chipselect ? gnt1 : last_q;
      rv_q <= ram_chipselect & ~ram_write;
      rown_q <= gnt1;
    end
  end
endmodule

// File: tb/tb_qsys_ram_arbiter.sv
// tb_qsys_ram_arbiter: directed scenarios against a behavioural RAM, plus a fixed-priority instance
module tb_qsys_ram_arbiter;
  logic clk = 0, reset;
  logic [9:0] m0_address, m1_address, ram_address, fp_addr;
  logic [3:0] m0_byteenable, m1_byteenable, ram_byteenable, fp_be;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, ram_writedata, ram_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic ram_chipselect, ram_write, ram_clken;
  logic fp_m0_wait, fp_m1_wait, fp_m0_rdv, fp_m1_rdv, fp_cs, fp_wr, fp_clken;
  logic [31:0] fp_m0_rd, fp_m1_rd, fp_wd, fp_q;
  logic [31:0] mem [0:1023];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  qsys_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  qsys_ram_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(fp_m0_wait), .m0_readdata(fp_m0_rd),
    .m0_readdatavalid(fp_m0_rdv),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(fp_m1_wait), .m1_readdata(fp_m1_rd),
    .m1_readdatavalid(fp_m1_rdv),
    .ram_address(fp_addr), .ram_byteenable(fp_be), .ram_chipselect(fp_cs),
    .ram_write(fp_wr), .ram_writedata(fp_wd), .ram_clken(fp_clken), .ram_readdata(fp_q)
  );

  // RAM contents start as 0xA500_0000 | address after every reset
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
    else if (ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++) if (ram_byteenable[b]) mem[ram_address][b*8+:8] <= ram_writedata[b*8+:8];
    ram_readdata <= mem[ram_address];
  end

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
  endtask

  task automatic test_reset();
    reset = 1; m0_read = 1; m0_address = 10'h010; m1_read = 1; m1_address = 10'h020;
    @(posedge clk); @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got=%b exp=1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait got=%b exp=1", m1_waitrequest); end
    checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got=%b exp=0", ram_chipselect); end
    checks++; if (ram_clken !== 1'b1) begin errors++; $display("FAIL rst_clken got=%b exp=1", ram_clken); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_m0_rdv got=%b exp=0", m0_readdatavalid); end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL first_m0_wait got=%b exp=0", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL first_m1_wait got=%b exp=1", m1_waitrequest); end
    checks++; if (ram_address !== 10'h010) begin errors++; $display("FAIL first_addr got=%h exp=010", ram_address); end
    @(posedge clk); #1 m0_read = 0;
    @(negedge clk);
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL second_m1_wait got=%b exp=0", m1_waitrequest); end
    checks++; if (ram_address !== 10'h020) begin errors++; $display("FAIL second_addr got=%h exp=020", ram_address); end
    checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL first_m0_rdv got=%b exp=1", m0_readdatavalid); end
    checks++; if (m0_readdata !== 32'hA500_0010) begin errors++; $display("FAIL first_m0_data got=%h exp=a5000010", m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL first_m1_rdv got=%b exp=0", m1_readdatavalid); end
    @(posedge clk); #1 m1_read = 0;
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL second_m1_rdv got=%b exp=1", m1_readdatavalid); end
    checks++; if (m1_readdata !== 32'hA500_0020) begin errors++; $display("FAIL second_m1_data got=%h exp=a5000020", m1_readdata); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL second_m0_rdv got=%b exp=0", m0_readdatavalid); end
    checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got=%b exp=0", ram_chipselect); end
  endtask

  task automatic test_read_after_write();
    @(posedge clk); #1 m0_write = 1; m0_address = 10'h3FF; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL raw_m0_wait got=%b exp=0", m0_waitrequest); end
    checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL raw_ram_write got=%b exp=1", ram_write); end
    checks++; if (ram_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_wdata got=%h exp=deadbeef", ram_writedata); end
    @(posedge clk); #1 idle(); m1_read = 1; m1_address = 10'h3FF;
    @(negedge clk);
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL raw_m1_wait got=%b exp=0", m1_waitrequest); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL raw_write_rdv got=%b exp=0", m0_readdatavalid); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL raw_m1_rdv got=%b exp=1", m1_readdatavalid); end
    checks++; if (m1_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_m1_data got=%h exp=deadbeef", m1_readdata); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL raw_m0_rdv got=%b exp=0", m0_readdatavalid); end
  endtask

  task automatic test_illegal_rw();
    @(posedge clk); #1 m0_read = 1; m0_write = 1; m0_address = 10'h066; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL ill_ram_write got=%b exp=1", ram_write); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL ill_rdv got=%b exp=0", m0_readdatavalid); end
    @(posedge clk); #1 m0_read = 1; m0_address = 10'h066;
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (m0_readdata !== 32'h1234_5678) begin errors++; $display("FAIL ill_data got=%h exp=12345678", m0_readdata); end
  endtask

  // m0 was granted last, so m1 takes the even cycles and m0 the odd ones
  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, r0 = 0, r1 = 0;
    logic w0, w1;
    @(posedge clk); #1 m0_read = 1; m0_address = 10'h100; m1_read = 1; m1_address = 10'h200;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      w0 = m0_waitrequest; w1 = m1_waitrequest;
      checks++; if (ram_chipselect !== (k < 16)) begin errors++; $display("FAIL b2b_cs k=%0d got=%b exp=%b", k, ram_chipselect, k < 16); end
      if (k < 16) begin
        checks++; if (w0 !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_m0_wait k=%0d got=%b exp=%b", k, w0, k % 2 == 0); end
        checks++; if (w1 !== (k % 2 == 1 && k < 15)) begin errors++; $display("FAIL b2b_m1_wait k=%0d got=%b exp=%b", k, w1, k % 2 == 1 && k < 15); end
      end
      if (k > 0) begin
        r0 += int'(m0_readdatavalid); r1 += int'(m1_readdatavalid);
        if ((k - 1) % 2 == 0) begin
          checks++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== (32'hA500_0200 + (k - 1) / 2))
            begin errors++; $display("FAIL b2b_m1_ret k=%0d got=%b%b/%h exp=01/%h", k, m0_readdatavalid, m1_readdatavalid, m1_readdata, 32'hA500_0200 + (k - 1) / 2); end
        end else begin
          checks++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== (32'hA500_0100 + (k - 1) / 2))
            begin errors++; $display("FAIL b2b_m0_ret k=%0d got=%b%b/%h exp=10/%h", k, m0_readdatavalid, m1_readdatavalid, m0_readdata, 32'hA500_0100 + (k - 1) / 2); end
        end
      end
      @(posedge clk); #1;
      if (m0_read && !w0) begin n0++; if (n0 == 8) m0_read = 0; else m0_address = 10'(32'h100 + n0); end
      if (m1_read && !w1) begin n1++; if (n1 == 8) m1_read = 0; else m1_address = 10'(32'h200 + n1); end
    end
    checks++; if (r0 != 8 || r1 != 8) begin errors++; $display("FAIL b2b_pulses got=%0d/%0d exp=8/8", r0, r1); end
    idle();
  endtask

  task automatic test_byte_lane();
    @(posedge clk); #1 m1_write = 1; m1_address = 10'h055; m1_writedata = 32'hAAAA_AAAA; m1_byteenable = 4'hF;
    @(posedge clk); #1 m1_writedata = 32'h1122_3344; m1_byteenable = 4'h5;
    @(negedge clk);
    checks++; if (ram_byteenable !== 4'h5) begin errors++; $display("FAIL be_ram_be got=%h exp=5", ram_byteenable); end
    @(posedge clk); #1 idle(); m1_read = 1; m1_address = 10'h055;
    @(posedge clk); #1 idle();
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL be_rdv got=%b exp=1", m1_readdatavalid); end
    checks++; if (m1_readdata !== 32'hAA22_AA44) begin errors++; $display("FAIL be_data got=%h exp=aa22aa44", m1_readdata); end
  endtask

  task automatic test_fixed_priority();
    @(posedge clk); #1 m0_read = 1; m0_address = 10'h001; m1_read = 1; m1_address = 10'h002;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (fp_m0_wait !== 1'b0 || fp_m1_wait !== 1'b1 || fp_cs !== 1'b1 || fp_addr !== 10'h001)
        begin errors++; $display("FAIL fp_contend k=%0d got=%b%b%b/%h exp=011/001", k, fp_m0_wait, fp_m1_wait, fp_cs, fp_addr); end
      if (k > 0) begin
        checks++; if (fp_m0_rdv !== 1'b1 || fp_m1_rdv !== 1'b0) begin errors++; $display("FAIL fp_rdv k=%0d got=%b%b exp=10", k, fp_m0_rdv, fp_m1_rdv); end
      end
      @(posedge clk); #1;
    end
    m0_read = 0;
    @(negedge clk);
    checks++; if (fp_m1_wait !== 1'b0 || fp_addr !== 10'h002) begin errors++; $display("FAIL fp_m1_grant got=%b/%h exp=0/002", fp_m1_wait, fp_addr); end
    checks++; if (fp_wr !== 1'b0 || fp_clken !== 1'b1 || fp_be !== 4'h0 || fp_wd !== 32'h0 || fp_m0_rd !== 32'h0 || fp_m1_rd !== 32'h0)
      begin errors++; $display("FAIL fp_misc got=%b%b%h %h %h %h exp=010 0 0 0", fp_wr, fp_clken, fp_be, fp_wd, fp_m0_rd, fp_m1_rd); end
    @(posedge clk); #1 idle();
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1 m0_read = 1; m0_address = 10'h010;
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_grant got=%b exp=0", m0_waitrequest); end
    @(posedge clk); #1 m0_read = 0; reset = 1;
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_rdv_rst got=%b exp=0", m0_readdatavalid); end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_rdv_post got=%b exp=0", m0_readdatavalid); end
    @(posedge clk); #1 m0_read = 1; m0_address = 10'h011; m1_read = 1; m1_address = 10'h012;
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_last_q got=%b%b exp=01", m0_waitrequest, m1_waitrequest); end
    @(posedge clk); #1 idle();
  endtask

  initial begin
    fp_q = 32'h0;
    idle();
    test_reset();
    test_read_after_write();
    test_illegal_rw();
    test_back_to_back();
    test_byte_lane();
    test_fixed_priority();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
